// File: rtl/block_dispatch_ctrl.sv
// Two-entry block buffer and AES/CRC/MD5 dispatch sequencer.
// Optional RUN watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module block_dispatch_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         key_done,
    input  logic [127:0] blk_data,
    input  logic         blk_valid,
    input  logic [2:0]   eng_mask,
    output logic [127:0] eng_data,
    output logic [2:0]   eng_start,
    input  logic [2:0]   eng_done,
    output logic         busy,
    output logic [15:0]  blk_cnt,
    output logic [7:0]   drop_cnt,
    output logic [1:0]   fifo_level,
    output logic         timeout_flag
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        RETIRE
    } state_t;

    state_t       state, state_nx;
    logic [127:0] mem [FIFO_DEPTH];
    logic         rd_ptr, wr_ptr;
    logic [2:0]   pend, pend_nx;
    logic         push, pop, drop;
    logic         force_retire;

    assign pop     = (state == RETIRE);
    // A full buffer still accepts a block in the cycle its head retires.
    assign push    = blk_valid & key_done & ((fifo_level != 2'd2) | pop);
    assign drop    = blk_valid & key_done & ~push;
    assign pend_nx = pend & ~eng_done;
    assign busy    = (state != IDLE) || (fifo_level != 2'd0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (fifo_level != 2'd0 && key_done) state_nx = LAUNCH;
            LAUNCH:
                state_nx = (eng_mask == 3'b000) ? RETIRE : RUN;
            RUN:
                if (pend_nx == 3'b000 || force_retire) state_nx = RETIRE;
            RETIRE:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (push) mem[wr_ptr] <= blk_data;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_level <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      fifo_level <= fifo_level + 2'd1;
            else if (pop && !push) fifo_level <= fifo_level - 2'd1;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            eng_data  <= '0;
            eng_start <= '0;
            pend      <= '0;
            blk_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nx;
            eng_start <= '0;
            if (state == LAUNCH) begin
                eng_data  <= mem[rd_ptr];
                pend      <= eng_mask;
                eng_start <= eng_mask;
            end
            if (state == RUN) pend <= pend_nx;
            if (pop) blk_cnt <= blk_cnt + 16'd1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] tcnt;

    assign force_retire = (state == RUN) && (pend_nx != 3'b000) &&
                          (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            tcnt         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == LAUNCH)   tcnt <= '0;
            else if (state == RUN) tcnt <= tcnt + TW'(1);
            if (force_retire) timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign force_retire       = 1'b0;
    assign timeout_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_block_dispatch_ctrl.sv
// Directed bench for block_dispatch_ctrl: vector table plus corner sequences.
// Define DISPATCH_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_block_dispatch_ctrl;

    logic         sclk = 1'b0;
    logic         rst;
    logic         key_done;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic [2:0]   eng_mask;
    logic [127:0] eng_data;
    logic [2:0]   eng_start;
    logic [2:0]   eng_done;
    logic         busy;
    logic [15:0]  blk_cnt;
    logic [7:0]   drop_cnt;
    logic [1:0]   fifo_level;
    logic         timeout_flag;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_blk   = 0;
    int exp_drop  = 0;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   mask;
    } vec_t;

    vec_t vecs [5];

    block_dispatch_ctrl #(.FIFO_DEPTH(2), .TIMEOUT_CYC(16)) dut (
        .sclk(sclk),
        .rst(rst),
        .key_done(key_done),
        .blk_data(blk_data),
        .blk_valid(blk_valid),
        .eng_mask(eng_mask),
        .eng_data(eng_data),
        .eng_start(eng_start),
        .eng_done(eng_done),
        .busy(busy),
        .blk_cnt(blk_cnt),
        .drop_cnt(drop_cnt),
        .fifo_level(fifo_level),
        .timeout_flag(timeout_flag)
    );

    always #5 sclk = ~sclk;

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, eng_data, 128'h0);
        chk({tag, "_start"}, 128'(eng_start), 128'h0);
        chk({tag, "_busy"}, 128'(busy), 128'h0);
        chk({tag, "_blk"}, 128'(blk_cnt), 128'h0);
        chk({tag, "_drop"}, 128'(drop_cnt), 128'h0);
        chk({tag, "_level"}, 128'(fifo_level), 128'h0);
        chk({tag, "_tflag"}, 128'(timeout_flag), 128'h0);
    endtask

    task automatic pulse_block(input logic [127:0] d);
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    // Entered on the first RUN cycle; leaves on the IDLE cycle after RETIRE.
    task automatic serve(input logic [127:0] d, input logic [2:0] m);
        int ord [3] = '{0, 2, 1};
        bit first = 1'b1;
        chk("start_pulse", 128'(eng_start), 128'(m));
        chk("eng_data", eng_data, d);
        for (int k = 0; k < 3; k++) begin
            if (m[ord[k]]) begin
                eng_done = 3'(1 << ord[k]);
                tick();
                if (first) chk("start_once", 128'(eng_start), 128'h0);
                first = 1'b0;
            end
        end
        eng_done = 3'b000;
        chk("retire_cnt_hold", 128'(blk_cnt), 128'(exp_blk));
        chk("retire_busy", 128'(busy), 128'h1);
        tick();
        exp_blk++;
        chk("retire_cnt", 128'(blk_cnt), 128'(exp_blk));
    endtask

    initial begin
        vecs[0] = '{128'h0123456789ABCDEF0123456789ABCDEF, 3'b111};
        vecs[1] = '{128'hDEADBEEF_00000000_FFFFFFFF_12345678, 3'b010};
        vecs[2] = '{128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 3'b101};
        vecs[3] = '{128'h11112222_33334444_55556666_77778888, 3'b000};
        vecs[4] = '{128'hFEDCBA98_76543210_00FF00FF_FF00FF00, 3'b100};

        rst       = 1'b1;
        key_done  = 1'b0;
        blk_data  = '0;
        blk_valid = 1'b0;
        eng_mask  = 3'b000;
        eng_done  = 3'b000;
        tick();
        tick();
        chk_all_zero("reset");
        rst      = 1'b0;
        key_done = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            eng_mask = vecs[i].mask;
            pulse_block(vecs[i].data);
            chk("level_one", 128'(fifo_level), 128'h1);
            tick();
            chk("start_early", 128'(eng_start), 128'h0);
            tick();
            if (vecs[i].mask != 3'b000) begin
                serve(vecs[i].data, vecs[i].mask);
            end else begin
                chk("nomask_start", 128'(eng_start), 128'h0);
                chk("nomask_data", eng_data, vecs[i].data);
                chk("nomask_hold", 128'(blk_cnt), 128'(exp_blk));
                tick();
                exp_blk++;
                chk("nomask_cnt", 128'(blk_cnt), 128'(exp_blk));
            end
            chk("vec_busy", 128'(busy), 128'h0);
            chk("vec_level", 128'(fifo_level), 128'h0);
        end

        // Three back-to-back blocks while the engine stalls; third drops.
        eng_mask  = 3'b001;
        blk_valid = 1'b1;
        blk_data  = 128'hD0;
        tick();
        blk_data  = 128'hD1;
        tick();
        blk_data  = 128'hD2;
        tick();
        blk_valid = 1'b0;
        exp_drop++;
        chk("full_level", 128'(fifo_level), 128'h2);
        chk("full_drop", 128'(drop_cnt), 128'(exp_drop));
        chk("stall_start", 128'(eng_start), 128'h1);
        chk("stall_data", eng_data, 128'hD0);
        repeat (5) tick();
        chk("stall_level", 128'(fifo_level), 128'h2);
        chk("stall_busy", 128'(busy), 128'h1);
        chk("stall_nostart", 128'(eng_start), 128'h0);
        eng_done = 3'b001;
        tick();
        eng_done  = 3'b000;
        blk_data  = 128'hD3;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        exp_blk++;
        chk("pop_push_level", 128'(fifo_level), 128'h2);
        chk("pop_push_drop", 128'(drop_cnt), 128'(exp_drop));
        chk("pop_push_cnt", 128'(blk_cnt), 128'(exp_blk));
        tick();
        tick();
        serve(128'hD1, 3'b001);
        tick();
        tick();
        serve(128'hD3, 3'b001);
        chk("drain_level", 128'(fifo_level), 128'h0);
        chk("drain_busy", 128'(busy), 128'h0);

        // Blocks offered without a key are ignored, not counted.
        key_done  = 1'b0;
        blk_valid = 1'b1;
        blk_data  = 128'hE0;
        repeat (3) tick();
        blk_valid = 1'b0;
        tick();
        chk("nokey_level", 128'(fifo_level), 128'h0);
        chk("nokey_drop", 128'(drop_cnt), 128'(exp_drop));
        chk("nokey_busy", 128'(busy), 128'h0);
        key_done = 1'b1;

        // Key lost mid-RUN: current block finishes, next one waits.
        eng_mask  = 3'b001;
        blk_valid = 1'b1;
        blk_data  = 128'hA0;
        tick();
        blk_data  = 128'hB0;
        tick();
        blk_valid = 1'b0;
        tick();
        key_done = 1'b0;
        serve(128'hA0, 3'b001);
        repeat (3) tick();
        chk("keyoff_level", 128'(fifo_level), 128'h1);
        chk("keyoff_busy", 128'(busy), 128'h1);
        chk("keyoff_nostart", 128'(eng_start), 128'h0);
        chk("keyoff_cnt", 128'(blk_cnt), 128'(exp_blk));
        key_done = 1'b1;
        tick();
        tick();
        serve(128'hB0, 3'b001);

`ifdef DISPATCH_TIMEOUT_EN
        eng_mask = 3'b010;
        pulse_block(128'hC0);
        tick();
        tick();
        chk("to_start", 128'(eng_start), 128'h2);
        repeat (15) tick();
        chk("to_flag_early", 128'(timeout_flag), 128'h0);
        chk("to_busy", 128'(busy), 128'h1);
        tick();
        chk("to_flag", 128'(timeout_flag), 128'h1);
        chk("to_cnt_hold", 128'(blk_cnt), 128'(exp_blk));
        tick();
        exp_blk++;
        chk("to_cnt", 128'(blk_cnt), 128'(exp_blk));
        eng_done = 3'b010;
        tick();
        eng_done = 3'b000;
        tick();
        chk("late_done_cnt", 128'(blk_cnt), 128'(exp_blk));
        chk("late_done_busy", 128'(busy), 128'h0);
        chk("to_sticky", 128'(timeout_flag), 128'h1);
`else
        chk("no_timeout_flag", 128'(timeout_flag), 128'h0);
`endif

        // Asynchronous reset while a block is running.
        eng_mask = 3'b010;
        pulse_block(128'hF0);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 128'(busy), 128'h1);
        chk("pre_rst_data", eng_data, 128'hF0);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 128'(busy), 128'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
